// File: rtl/reg_window_spill_fill.sv
// Register-window overflow/underflow engine: spills the oldest 4-register group to a
// memory stack on save overflow, fills it back on restore underflow.
module reg_window_spill_fill #(
  parameter logic [15:0] STACK_BASE  = 16'hFF00,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        win_valid,
  input  logic [1:0]  win_op,
  output logic        win_ready,
  output logic        win_err,
  output logic [4:0]  win_index,
  output logic [4:0]  rf_sel,
  input  logic [15:0] rf_rd_data,
  output logic [15:0] rf_wr_data,
  output logic        rf_load_L,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned   CW      = $clog2(STACK_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);
  localparam logic [1:0]    OP_SAVE = 2'b10;
  localparam logic [1:0]    OP_REST = 2'b01;

  typedef enum logic [1:0] {IDLE, SPILL, FILL_RD, FILL_WR} state_t;

  state_t        state, state_nx;
  logic [4:0]    idx_q, idx_nx;
  logic [2:0]    res_q, res_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [1:0]    k_q, k_nx;
  logic [15:0]   latch_q, latch_nx;
  logic          err_q, err_nx;

  logic [2:0]    spill_grp, fill_grp;
  logic [CW-1:0] slot;
  logic [15:0]   slot_addr;

  // Groups are derived from the live index: it only moves when a spill/fill completes.
  assign spill_grp = idx_q[4:2] + 3'd2;
  assign fill_grp  = idx_q[4:2] - 3'd1;
  assign slot      = (state == FILL_RD) ? cnt_q - 1'b1 : cnt_q;
  assign slot_addr = STACK_BASE + 16'({slot, 2'b00}) + 16'(k_q);

  assign win_ready = (state == IDLE);
  assign win_err   = err_q;
  assign win_index = idx_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      idx_q   <= idx_nx;
      res_q   <= res_nx;
      cnt_q   <= cnt_nx;
      k_q     <= k_nx;
      latch_q <= latch_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx_q;
    res_nx     = res_q;
    cnt_nx     = cnt_q;
    k_nx       = k_q;
    latch_nx   = latch_q;
    err_nx     = 1'b0;
    rf_sel     = '0;
    rf_wr_data = '0;
    rf_load_L  = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state)
      IDLE: begin
        if (win_valid && win_op == OP_SAVE) begin
          if (res_q != 3'd6) begin
            idx_nx = idx_q + 5'd4;
            res_nx = res_q + 3'd1;
          end else if (cnt_q != DEPTH_C) begin
            state_nx = SPILL;
            k_nx     = '0;
          end else begin
            err_nx = 1'b1;
          end
        end else if (win_valid && win_op == OP_REST) begin
          if (res_q != 3'd0) begin
            idx_nx = idx_q - 5'd4;
            res_nx = res_q - 3'd1;
          end else if (cnt_q != '0) begin
            state_nx = FILL_RD;
            k_nx     = '0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      SPILL: begin
        rf_sel    = {spill_grp, k_q};
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = slot_addr;
        mem_wdata = rf_rd_data;
        if (mem_ack) begin
          k_nx = k_q + 2'd1;
          if (k_q == 2'd3) begin
            cnt_nx   = cnt_q + 1'b1;
            idx_nx   = idx_q + 5'd4;
            state_nx = IDLE;
          end
        end
      end

      FILL_RD: begin
        mem_req  = 1'b1;
        mem_addr = slot_addr;
        if (mem_ack) begin
          latch_nx = mem_rdata;
          state_nx = FILL_WR;
        end
      end

      FILL_WR: begin
        rf_sel     = {fill_grp, k_q};
        rf_wr_data = latch_q;
        rf_load_L  = 1'b0;
        k_nx       = k_q + 2'd1;
        if (k_q == 2'd3) begin
          cnt_nx   = cnt_q - 1'b1;
          idx_nx   = idx_q - 5'd4;
          state_nx = IDLE;
        end else begin
          state_nx = FILL_RD;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_window_spill_fill.sv
// Bench for reg_window_spill_fill: register-file and memory models around the DUT,
// checked against a window/stack reference model.
`timescale 1ns/1ps
module tb_reg_window_spill_fill;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 16;
  localparam logic [1:0]  SAVE  = 2'b10;
  localparam logic [1:0]  REST  = 2'b01;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic        win_valid = 1'b0;
  logic [1:0]  win_op = 2'b00;
  logic        win_ready, win_err;
  logic [4:0]  win_index, rf_sel;
  logic [15:0] rf_rd_data, rf_wr_data;
  logic        rf_load_L, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  reg_window_spill_fill #(.STACK_BASE(BASE), .STACK_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_L(reset_L), .win_valid(win_valid), .win_op(win_op),
    .win_ready(win_ready), .win_err(win_err), .win_index(win_index), .rf_sel(rf_sel),
    .rf_rd_data(rf_rd_data), .rf_wr_data(rf_wr_data), .rf_load_L(rf_load_L),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Environment: register file, memory with configurable wait, transaction log
  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] data; } tx_t;
  tx_t         tx_q[$];
  logic [15:0] rf [32];
  logic [15:0] pre_vals [32];
  logic        pre_we = 1'b0;
  logic [15:0] mem_store [256];
  int          ack_delay = 0;
  int          wcnt;

  assign rf_rd_data = rf[rf_sel];
  assign mem_rdata  = mem_store[mem_addr[7:0]];
  assign mem_ack    = mem_req && (wcnt == ack_delay);

  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clock) begin
    if (reset_L && mem_req && mem_ack) begin
      tx_q.push_back({mem_we, mem_addr, mem_wdata});
      if (mem_we) mem_store[mem_addr[7:0]] <= mem_wdata;
    end
    if (pre_we) rf <= pre_vals;
    else if (!rf_load_L) rf[rf_sel] <= rf_wr_data;
  end

  // Counts address/data changes while a memory request is waiting for its ack
  int          stab_bad = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  always @(negedge clock) begin
    if (mem_req && hold_prev && (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
      stab_bad <= stab_bad + 1;
    hold_prev  <= mem_req && !mem_ack;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  // Reference model: window index, resident frames, stack of spilled words, register contents
  int          m_idx, m_res;
  logic [15:0] m_stack[$];
  logic [15:0] m_rf [32];

  task automatic model_reset();
    m_idx = 0;
    m_res = 0;
    m_stack.delete();
  endtask

  task automatic do_reset();
    win_valid = 1'b0;
    win_op    = 2'b00;
    reset_L   = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;
    model_reset();
  endtask

  task automatic preset_rf();
    pre_vals = m_rf;
    pre_we   = 1'b1;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 32; i++) m_rf[i] = 16'($urandom);
    preset_rf();
  endtask

  // Issues one window request, steps the model, checks every observable effect
  task automatic run_op(input logic [1:0] op, input int d, input string tag);
    int   busy, base, g, grp, exp_busy, bad;
    logic exp_err;
    tx_t  exp_tx[$];
    tx_t  got;
    exp_err  = 1'b0;
    exp_busy = 0;
    g = m_stack.size() / 4;
    if (op == SAVE) begin
      if (m_res < 6) begin
        m_idx = (m_idx + 4) % 32;
        m_res++;
      end else if (g < DEPTH) begin
        grp = ((m_idx / 4) + 2) % 8;
        for (int k = 0; k < 4; k++) begin
          exp_tx.push_back({1'b1, 16'(BASE + 4 * g + k), m_rf[grp * 4 + k]});
          m_stack.push_back(m_rf[grp * 4 + k]);
        end
        m_idx = (m_idx + 4) % 32;
        exp_busy = 4 * (d + 1);
      end else begin
        exp_err = 1'b1;
      end
    end else if (op == REST) begin
      if (m_res > 0) begin
        m_idx = (m_idx + 28) % 32;
        m_res--;
      end else if (g > 0) begin
        grp = ((m_idx / 4) + 7) % 8;
        for (int k = 0; k < 4; k++)
          exp_tx.push_back({1'b0, 16'(BASE + 4 * (g - 1) + k), 16'h0000});
        for (int k = 3; k >= 0; k--) m_rf[grp * 4 + k] = m_stack.pop_back();
        m_idx = (m_idx + 28) % 32;
        exp_busy = 4 * (d + 1) + 4;
      end else begin
        exp_err = 1'b1;
      end
    end

    ack_delay = d;
    base      = tx_q.size();
    win_op    = op;
    win_valid = 1'b1;
    @(posedge clock);
    #1 win_valid = 1'b0;
    win_op = 2'b00;

    tests_run++;
    if (win_err !== exp_err) begin
      tests_failed++;
      $display("FAIL %s err: got %b want %b", tag, win_err, exp_err);
    end
    busy = 0;
    while (win_ready !== 1'b1 && busy < 200) begin
      busy++;
      @(posedge clock);
      #1;
    end
    tests_run++;
    if (busy != exp_busy) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy, exp_busy);
    end
    if (exp_err) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (win_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s err_pulse_len: got %b want 0", tag, win_err);
      end
    end
    tests_run++;
    if (win_index !== 5'(m_idx)) begin
      tests_failed++;
      $display("FAIL %s win_index: got %0d want %0d", tag, win_index, m_idx);
    end
    tests_run++;
    if (tx_q.size() - base != exp_tx.size()) begin
      tests_failed++;
      $display("FAIL %s mem_tx_count: got %0d want %0d", tag, tx_q.size() - base, exp_tx.size());
    end else begin
      for (int i = 0; i < exp_tx.size(); i++) begin
        got = tx_q[base + i];
        if (!exp_tx[i].we) got.data = 16'h0000;
        tests_run++;
        if (got !== exp_tx[i]) begin
          tests_failed++;
          $display("FAIL %s mem_tx%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h", tag, i,
                   got.we, got.addr, got.data, exp_tx[i].we, exp_tx[i].addr, exp_tx[i].data);
        end
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== m_rf[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s rf_contents: %0d regs differ, want 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    #3;
    tests_run++;
    if (rf_load_L !== 1'b1 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_during: got load_L=%b req=%b want 1 0", rf_load_L, mem_req);
    end
    do_reset();
    tests_run++;
    if ({win_ready, win_err, win_index, rf_sel, rf_wr_data, rf_load_L, mem_req, mem_we,
         mem_addr, mem_wdata} !== {1'b1, 1'b0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_values: got rdy=%b err=%b idx=%0d sel=%0d wd=%h ld=%b req=%b we=%b a=%h d=%h want 1 0 0 0 0 1 0 0 0 0",
               win_ready, win_err, win_index, rf_sel, rf_wr_data, rf_load_L, mem_req, mem_we,
               mem_addr, mem_wdata);
    end
    randomize_rf();
  endtask

  task automatic test_saves();
    run_op(2'b00, 0, "ignored_op00");
    run_op(2'b11, 0, "ignored_op11");
    for (int i = 0; i < 6; i++) run_op(SAVE, 0, "plain_save");
    tests_run++;
    if (win_index !== 5'd24) begin
      tests_failed++;
      $display("FAIL six_saves_index: got %0d want 24", win_index);
    end
  endtask

  task automatic test_spill();
    for (int i = 0; i < 4; i++) m_rf[i] = 16'hA000 + 16'(i);
    preset_rf();
    run_op(SAVE, 0, "spill_zero_wait");
    tests_run++;
    if (win_index !== 5'd28 || mem_store[0] !== 16'hA000 || mem_store[3] !== 16'hA003) begin
      tests_failed++;
      $display("FAIL spill_result: got idx=%0d m0=%h m3=%h want 28 a000 a003",
               win_index, mem_store[0], mem_store[3]);
    end
  endtask

  task automatic test_restore_fill();
    for (int i = 0; i < 4; i++) m_rf[i] = 16'h0000;
    preset_rf();
    for (int i = 0; i < 6; i++) run_op(REST, 0, "plain_restore");
    run_op(REST, 0, "fill_zero_wait");
    tests_run++;
    if (win_index !== 5'd0 || rf[0] !== 16'hA000 || rf[3] !== 16'hA003) begin
      tests_failed++;
      $display("FAIL fill_result: got idx=%0d r0=%h r3=%h want 0 a000 a003", win_index, rf[0], rf[3]);
    end
  endtask

  task automatic test_underflow();
    run_op(REST, 0, "underflow_err");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6 + DEPTH; i++) run_op(SAVE, i % 2, "fill_stack");
    run_op(SAVE, 0, "overflow_err");
    run_op(REST, 1, "fill_after_overflow");
  endtask

  task automatic test_wait_spill();
    int bad0;
    do_reset();
    for (int i = 0; i < 6; i++) run_op(SAVE, 0, "plain_save");
    bad0 = stab_bad;
    run_op(SAVE, 3, "spill_wait3");
    tests_run++;
    if (stab_bad != bad0) begin
      tests_failed++;
      $display("FAIL wait_stability: got %0d changes want 0", stab_bad - bad0);
    end
  endtask

  task automatic test_reset_mid_spill();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) run_op(SAVE, 0, "plain_save");
    ack_delay = 3;
    win_op    = SAVE;
    win_valid = 1'b1;
    @(posedge clock);
    #1 win_valid = 1'b0;
    win_op = 2'b00;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === BASE + 16'd1) && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    tests_run++;
    if (n >= 40) begin
      tests_failed++;
      $display("FAIL reach_beat2: got timeout want mem_addr %h", BASE + 16'd1);
    end
    #2 reset_L = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_abort: got mem_req=%b want 0", mem_req);
    end
    @(posedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    tests_run++;
    if (win_index !== 5'd0 || win_ready !== 1'b1 || win_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_abort: got idx=%0d rdy=%b err=%b want 0 1 0", win_index, win_ready, win_err);
    end
    for (int i = 0; i < 7; i++) run_op(SAVE, 0, "post_abort_save");
    run_op(REST, 0, "post_abort_restore");
  endtask

  task automatic test_random();
    int r, pct_save;
    logic [1:0] op;
    do_reset();
    randomize_rf();
    for (int i = 0; i < 240; i++) begin
      pct_save = (i < 120) ? 70 : 30;
      if ($urandom_range(0, 9) == 0) randomize_rf();
      r = $urandom_range(0, 99);
      if (r < 8) op = 2'($urandom_range(0, 1) * 3);
      else if (r < 8 + (92 * pct_save) / 100) op = SAVE;
      else op = REST;
      run_op(op, $urandom_range(0, 2), "random_op");
    end
  endtask

  initial begin
    test_reset();
    test_saves();
    test_spill();
    test_restore_fill();
    test_underflow();
    test_overflow();
    test_wait_spill();
    test_reset_mid_spill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
